// File: rtl/disp_arb_pkg.sv
// Shared encodings and helpers for the seven-segment display arbiter.
// Latency: none (declarations and pure functions only).
// Backpressure: not applicable.
package disp_arb_pkg;

  localparam int NUM_REQ = 3;
  localparam int CNT_W   = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // One-hot grant vector for a requester index.
  function automatic logic [NUM_REQ-1:0] idx_onehot(input logic [1:0] idx);
    logic [NUM_REQ-1:0] one;
    one = 3'b001;
    return one << idx;
  endfunction

  // Next requester index in the circular order 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/seg_display_arbiter_if.sv
// Bundle between the display requesters and the display arbiter.
// Latency: none (wires only).
// Backpressure: none; requests are level-held until granted.
interface seg_display_arbiter_if;
  import disp_arb_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [15:0]        data0;
  logic [15:0]        data1;
  logic [15:0]        data2;
  logic [7:0]         led0;
  logic [7:0]         led1;
  logic [7:0]         led2;
  logic [NUM_REQ-1:0] gnt;
  logic [1:0]         owner;
  logic [15:0]        seg_data;
  logic [7:0]         led_data;
  logic               blank;
  logic               busy;
  logic               done;

  // Requester / display-driver side.
  modport master (
    output req, data0, data1, data2, led0, led1, led2,
    input  gnt, owner, seg_data, led_data, blank, busy, done
  );

  // Arbiter side.
  modport slave (
    input  req, data0, data1, data2, led0, led1, led2,
    output gnt, owner, seg_data, led_data, blank, busy, done
  );

endinterface

// File: rtl/disp_rr_pick.sv
// Round-robin winner selection among the display requesters.
// Latency: purely combinational.
// Backpressure: none; valid low when no request is pending.
module disp_rr_pick
  import disp_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         last,
  output logic               valid,
  output logic [1:0]         index
);

  // Walk the candidates starting just after last; the first one requesting wins.
  always_comb begin
    logic [1:0] cand;
    valid = 1'b0;
    index = last;
    cand  = last;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = rr_next(cand);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// Time-sliced round-robin arbiter sharing one seven-segment/LED display.
// Latency: grant 1 cycle after request; display data follows owner input by 1 cycle.
// Backpressure: none; losers keep REQ high and wait for their turn.
module seg_display_arbiter
  import disp_arb_pkg::*;
#(
  parameter int HOLD_CYCLES = 32000000,
  parameter int GAP_CYCLES  = 3200
) (
  input  logic                 clk,
  input  logic                 rst,
  seg_display_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  state_t           state,    state_nxt;
  logic [CNT_W-1:0] cnt,      cnt_nxt;
  logic [1:0]       owner,    owner_nxt;
  logic [1:0]       last,     last_nxt;
  logic [15:0]      seg_q,    seg_nxt;
  logic [7:0]       led_q,    led_nxt;
  logic             done_q,   done_nxt;

  logic             pick_vld;
  logic [1:0]       pick_idx;
  logic             owner_req;
  logic             other_vld;
  logic [15:0]      data_sel;
  logic [7:0]       led_sel;

  disp_rr_pick u_pick (
    .req   (bus.req),
    .last  (last),
    .valid (pick_vld),
    .index (pick_idx)
  );

  // Search starts after the owner, so the owner is only picked when nobody else asks.
  assign owner_req = bus.req[owner];
  assign other_vld = pick_vld && (pick_idx != owner);

  // Select the current owner's display and LED values.
  always_comb begin
    data_sel = bus.data0;
    led_sel  = bus.led0;
    case (owner)
      2'd1:    begin data_sel = bus.data1; led_sel = bus.led1; end
      2'd2:    begin data_sel = bus.data2; led_sel = bus.led2; end
      default: begin data_sel = bus.data0; led_sel = bus.led0; end
    endcase
  end

  // State, counter, ownership and display registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      owner  <= 2'd0;
      last   <= 2'd2;
      seg_q  <= '0;
      led_q  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      owner  <= owner_nxt;
      last   <= last_nxt;
      seg_q  <= seg_nxt;
      led_q  <= led_nxt;
      done_q <= done_nxt;
    end
  end

  // Next-state logic: grant, hold for a full slot, optional blanking gap, re-arbitrate.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    owner_nxt = owner;
    last_nxt  = last;
    seg_nxt   = seg_q;
    led_nxt   = led_q;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_vld) begin
          state_nxt = ST_HOLD;
          owner_nxt = pick_idx;
          last_nxt  = pick_idx;
          cnt_nxt   = '0;
        end
      end
      ST_HOLD: begin
        // A dropped request freezes the display but never cuts the slot short.
        if (owner_req) begin
          seg_nxt = data_sel;
          led_nxt = led_sel;
        end
        cnt_nxt = cnt + 1'b1;
        if (cnt == HOLD_LAST) begin
          cnt_nxt = '0;
          if (other_vld) begin
            done_nxt = 1'b1;
            if (GAP_CYCLES == 0) begin
              owner_nxt = pick_idx;
              last_nxt  = pick_idx;
            end else begin
              state_nxt = ST_GAP;
            end
          end else if (!owner_req) begin
            done_nxt  = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == GAP_LAST) begin
          cnt_nxt = '0;
          if (pick_vld) begin
            state_nxt = ST_HOLD;
            owner_nxt = pick_idx;
            last_nxt  = pick_idx;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.gnt      = (state == ST_HOLD) ? idx_onehot(owner) : '0;
  assign bus.owner    = owner;
  assign bus.seg_data = seg_q;
  assign bus.led_data = led_q;
  assign bus.blank    = (state == ST_GAP);
  assign bus.busy     = (state != ST_IDLE);
  assign bus.done     = done_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Self-checking bench: two arbiters (gap of 2 and gap of 0) share one stimulus
// stream and are compared every cycle against a slot-based reference model.
// Timing: inputs change on the falling edge, outputs are sampled on the falling edge.
module tb_seg_display_arbiter;

  localparam int HOLD = 8;
  localparam int M_IDLE = 0;
  localparam int M_HOLD = 1;
  localparam int M_GAP  = 2;

  logic        clk;
  logic        rst;
  logic [2:0]  req_s;
  logic [15:0] data_s [3];
  logic [7:0]  led_s  [3];

  int n_checks;
  int n_errors;

  seg_display_arbiter_if ifa ();
  seg_display_arbiter_if ifb ();

  assign ifa.req   = req_s;
  assign ifa.data0 = data_s[0];
  assign ifa.data1 = data_s[1];
  assign ifa.data2 = data_s[2];
  assign ifa.led0  = led_s[0];
  assign ifa.led1  = led_s[1];
  assign ifa.led2  = led_s[2];
  assign ifb.req   = req_s;
  assign ifb.data0 = data_s[0];
  assign ifb.data1 = data_s[1];
  assign ifb.data2 = data_s[2];
  assign ifb.led0  = led_s[0];
  assign ifb.led1  = led_s[1];
  assign ifb.led2  = led_s[2];

  seg_display_arbiter #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(2)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  seg_display_arbiter #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state, one slot per arbiter instance.
  int          gap_of     [2];
  int          m_mode     [2];
  int          m_owner    [2];
  int          m_last     [2];
  int          m_elapsed  [2];
  int          m_gap_left [2];
  logic [15:0] m_seg      [2];
  logic [7:0]  m_led      [2];
  logic        m_done     [2];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // First requester found scanning (last+1), (last+2), (last+3) mod 3; -1 if none.
  function automatic int rr_pick(input logic [2:0] r, input int lst);
    for (int k = 1; k <= 3; k++) begin
      if (r[(lst + k) % 3]) return (lst + k) % 3;
    end
    return -1;
  endfunction

  task automatic model_reset(input int k);
    m_mode[k]     = M_IDLE;
    m_owner[k]    = 0;
    m_last[k]     = 2;
    m_elapsed[k]  = 0;
    m_gap_left[k] = 0;
    m_seg[k]      = '0;
    m_led[k]      = '0;
    m_done[k]     = 1'b0;
  endtask

  task automatic model_grant(input int k, input int w);
    m_mode[k]    = M_HOLD;
    m_owner[k]   = w;
    m_last[k]    = w;
    m_elapsed[k] = 0;
  endtask

  // Advance one clock: slot of HOLD cycles, then gap of gap_of[k] cycles or handover.
  task automatic model_step(input int k);
    logic [2:0] others;
    int w;
    m_done[k] = 1'b0;
    if (m_mode[k] == M_IDLE) begin
      w = rr_pick(req_s, m_last[k]);
      if (w >= 0) model_grant(k, w);
    end else if (m_mode[k] == M_HOLD) begin
      if (req_s[m_owner[k]]) begin
        m_seg[k] = data_s[m_owner[k]];
        m_led[k] = led_s[m_owner[k]];
      end
      m_elapsed[k]++;
      if (m_elapsed[k] == HOLD) begin
        others = req_s & ~(3'b001 << m_owner[k]);
        if (others != 3'b000) begin
          m_done[k] = 1'b1;
          if (gap_of[k] > 0) begin
            m_mode[k]     = M_GAP;
            m_gap_left[k] = gap_of[k];
          end else begin
            model_grant(k, rr_pick(others, m_owner[k]));
          end
        end else if (req_s[m_owner[k]]) begin
          m_elapsed[k] = 0;
        end else begin
          m_done[k] = 1'b1;
          m_mode[k] = M_IDLE;
        end
      end
    end else begin
      m_gap_left[k]--;
      if (m_gap_left[k] == 0) begin
        w = rr_pick(req_s, m_last[k]);
        if (w >= 0) model_grant(k, w);
        else m_mode[k] = M_IDLE;
      end
    end
  endtask

  task automatic compare_all(input string ph);
    logic [2:0]  o_gnt, e_gnt;
    logic [1:0]  o_owner;
    logic [15:0] o_seg;
    logic [7:0]  o_led;
    logic        o_blank, o_busy, o_done;
    for (int k = 0; k < 2; k++) begin
      o_gnt   = (k == 0) ? ifa.gnt      : ifb.gnt;
      o_owner = (k == 0) ? ifa.owner    : ifb.owner;
      o_seg   = (k == 0) ? ifa.seg_data : ifb.seg_data;
      o_led   = (k == 0) ? ifa.led_data : ifb.led_data;
      o_blank = (k == 0) ? ifa.blank    : ifb.blank;
      o_busy  = (k == 0) ? ifa.busy     : ifb.busy;
      o_done  = (k == 0) ? ifa.done     : ifb.done;
      e_gnt   = (m_mode[k] == M_HOLD) ? (3'b001 << m_owner[k]) : 3'b000;
      check_val($sformatf("%s.%0d.gnt", ph, k),   32'(o_gnt),   32'(e_gnt));
      check_val($sformatf("%s.%0d.owner", ph, k), 32'(o_owner), 32'(m_owner[k]));
      check_val($sformatf("%s.%0d.seg", ph, k),   32'(o_seg),   32'(m_seg[k]));
      check_val($sformatf("%s.%0d.led", ph, k),   32'(o_led),   32'(m_led[k]));
      check_val($sformatf("%s.%0d.blank", ph, k), 32'(o_blank), 32'(m_mode[k] == M_GAP));
      check_val($sformatf("%s.%0d.busy", ph, k),  32'(o_busy),  32'(m_mode[k] != M_IDLE));
      check_val($sformatf("%s.%0d.done", ph, k),  32'(o_done),  32'(m_done[k]));
    end
  endtask

  // One clock with request pattern r and fresh random display data.
  task automatic run_cycle(input string ph, input logic [2:0] r, input bit fix0);
    req_s = r;
    for (int i = 0; i < 3; i++) begin
      data_s[i] = 16'($urandom);
      led_s[i]  = 8'($urandom);
    end
    if (fix0) data_s[0] = 16'h1234;
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    compare_all(ph);
  endtask

  // Asynchronous reset pulse launched between clock edges.
  task automatic pulse_reset(input string ph);
    rst = 1'b1;
    #1;
    model_reset(0);
    model_reset(1);
    compare_all(ph);
    @(posedge clk);
    @(negedge clk);
    compare_all(ph);
    rst = 1'b0;
  endtask

  initial begin
    logic [2:0] r;
    int len;
    n_checks  = 0;
    n_errors  = 0;
    gap_of[0] = 2;
    gap_of[1] = 0;
    rst   = 1'b1;
    req_s = 3'b000;
    for (int i = 0; i < 3; i++) begin
      data_s[i] = '0;
      led_s[i]  = '0;
    end
    model_reset(0);
    model_reset(1);
    @(negedge clk);
    compare_all("reset");
    rst = 1'b0;

    repeat (3)  run_cycle("idle", 3'b000, 1'b0);
    repeat (20) run_cycle("single", 3'b001, 1'b1);
    repeat (20) run_cycle("drain", 3'b000, 1'b0);
    repeat (45) run_cycle("all", 3'b111, 1'b0);
    repeat (20) run_cycle("drain", 3'b000, 1'b0);

    // Lone requester 1 drops after three slot cycles; slot still runs to term.
    repeat (3)  run_cycle("drop", 3'b010, 1'b0);
    repeat (12) run_cycle("drop", 3'b000, 1'b0);

    // Requester 2 alone, reset lands mid-slot, then 1 and 2 compete.
    repeat (6)  run_cycle("pre_rst", 3'b100, 1'b0);
    pulse_reset("arst");
    repeat (12) run_cycle("post_rst", 3'b110, 1'b0);
    repeat (20) run_cycle("pair", 3'b011, 1'b0);

    repeat (40) begin
      r   = 3'($urandom_range(0, 7));
      len = $urandom_range(1, 14);
      repeat (len) run_cycle("rand", r, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/seg_display_arbiter.md
SEG_DISPLAY_ARBITER -- requirements
Module: seg_display_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 32000000: minimum CLK cycles one owner keeps the display; legal values are 1 and above.
REQ-002 Parameter GAP_CYCLES, default 3200: blanking cycles between two different owners; 0 means no gap.
REQ-003 CLK  in  1  single clock, nominally 32 MHz; all state updates on its rising edge.
REQ-004 RST  in  1  reset, asynchronous, active-high.
REQ-005 REQ  in  3  per-requester display request, level-sensitive.
REQ-006 DATA0, DATA1, DATA2  in  16 each  requester 7-seg values, 4 hex digits.
REQ-007 LED0, LED1, LED2  in  8 each  requester LED values.
REQ-008 GNT  out  3  one-hot grant; all zero when no owner.
REQ-009 OWNER  out  2  index of current or last owner, 0..2.
REQ-010 SEG_DATA  out  16  registered seven_segment_data to the display driver.
REQ-011 LED_DATA  out  8  registered led_data to the display driver.
REQ-012 BLANK  out  1  high during GAP; the display driver blanks all anodes.
REQ-013 BUSY  out  1  high when state is not IDLE.
REQ-014 DONE  out  1  one-cycle pulse on the cycle HOLD is exited.

Function
REQ-015 The block SHALL implement FSM states IDLE, HOLD and GAP.
REQ-016 Arbitration SHALL be round-robin: the search order starts at (LAST+1) mod 3, LAST updates on every grant, and the first requester with REQ high wins.
REQ-017 IDLE: GNT=0 and BLANK=0, outputs hold their values; if any REQ is high, the next cycle SHALL be HOLD with GNT and OWNER set to the winner and the hold counter at 0.
REQ-018 HOLD: while REQ[OWNER]=1, SEG_DATA and LED_DATA SHALL register the owner's DATA/LED each cycle, one-cycle latency.
REQ-019 HOLD: if REQ[OWNER]=0, SEG_DATA and LED_DATA SHALL freeze; a dropped request SHALL NOT shorten the hold.
REQ-020 HOLD: the counter SHALL increment each cycle; expiry is count==HOLD_CYCLES-1.
REQ-021 At expiry, if another requester's REQ is high, the next state SHALL be GAP, or HOLD of the new winner when GAP_CYCLES=0.
REQ-022 Else, if REQ[OWNER] is still high, the block SHALL stay in HOLD with the counter restarted at 0, no DONE and no gap.
REQ-023 Else, the next state SHALL be IDLE.
REQ-024 DONE SHALL pulse on the cycle the FSM leaves HOLD, or restarts HOLD for a new owner.
REQ-025 GAP: GNT=0 and BLANK=1 for exactly GAP_CYCLES cycles, with the data outputs unchanged.
REQ-026 At the end of GAP, arbitration SHALL be re-evaluated: the next state is HOLD of the winner, or IDLE if no REQ is high.
REQ-027 Simultaneous requests SHALL resolve only by REQ-016; a requester asserting REQ during another's HOLD waits; requests need not be held continuously except at arbitration cycles.
REQ-028 The hold counter SHALL be 32 bits wide and SHALL NOT wrap within one hold period.

Reset
REQ-029 On RST=1, the block SHALL immediately set: state IDLE, GNT=0, OWNER=0, SEG_DATA=0, LED_DATA=0, BLANK=0, DONE=0, counters 0, and LAST=2 so requester 0 wins first.
REQ-030 RST asserted mid-HOLD or mid-GAP SHALL abort with no DONE pulse; on RST deassertion, arbitration resumes from IDLE.

Structure
REQ-031 A shared package disp_arb_pkg SHALL hold the FSM state encoding (IDLE=0, HOLD=1, GAP=2), NUM_REQ=3 and the counter width of 32.
REQ-032 Round-robin selection SHALL be a combinational sub-module disp_rr_pick (inputs REQ and LAST; outputs valid and index); all registers SHALL live in seg_display_arbiter.

Verification (HOLD_CYCLES=8, GAP_CYCLES=2)
REQ-033 Reset then REQ=3'b001, DATA0=16'h1234 -> GNT=001 one cycle later, SEG_DATA=1234 the cycle after, no DONE while REQ is held.
REQ-034 REQ=3'b111 held -> owners 0,1,2,0 in turn; each HOLD lasts 8 cycles; DONE pulses on each exit; BLANK high for 2 cycles between owners.
REQ-035 Owner 1 drops REQ at hold cycle 3, no other requests -> SEG_DATA frozen; IDLE after 8 total cycles; DONE pulses once.
REQ-036 RST pulsed at hold cycle 5 of owner 2 -> all outputs 0 immediately and no DONE; next REQ=3'b110 -> requester 1 wins.
REQ-037 GAP_CYCLES=0 with REQ=3'b011 -> direct HOLD-to-HOLD handover, BLANK never high, DONE on the handover cycle.
REQ-038 DATA0 changes every cycle during HOLD -> SEG_DATA equals DATA0 delayed exactly 1 cycle.
